seg7_capture: RTL

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_decode.sv | 29 ++
 rtl/seg7_capture.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, state type and anode helpers for the seven-segment scan capture.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] BCD_ERR   = 4'hF;

    // Active-low ABCDEFG patterns, index 9 on the left down to index 0 on the right.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
        7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic logic isSelected(input logic [3:0] an);
        logic sel;
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: sel = 1'b1;
            default:                            sel = 1'b0;
        endcase
        return sel;
    endfunction

    function automatic logic [1:0] anodeIndex(input logic [3:0] an);
        logic [1:0] idx;
        case (an)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern to BCD decoder; unknown patterns map to the error code.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_bcd,
    output logic       o_blank,
    output logic       o_err
);

    always_comb begin
        o_bcd   = BCD_ERR;
        o_blank = 1'b0;
        o_err   = 1'b1;
        if (i_seg == SEG_BLANK) begin
            o_bcd   = 4'h0;
            o_blank = 1'b1;
            o_err   = 1'b0;
        end else begin
            for (int d = 0; d < 10; d++) begin
                if (i_seg == SEG_DIGITS[d[3:0]]) begin
                    o_bcd = d[3:0];
                    o_err = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// Captures a multiplexed 4-digit seven-segment scan into a registered BCD frame,
// accepting a digit only after its anode/segment sample has been stable long enough.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an_in,
    input  logic [6:0]  seg_in,
    output logic [15:0] digits_out,
    output logic [3:0]  blank_out,
    output logic [3:0]  err_out,
    output logic        frame_valid,
    output logic        timeout_err
);

    localparam logic [8:0]  STABLE_W  = 9'(STABLE_CYCLES);
    localparam logic [20:0] TIMEOUT_W = 21'(TIMEOUT_CYCLES);
    localparam logic        ONE_SHOT  = (STABLE_CYCLES == 1);

    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic [3:0]  r_prevAn;
    logic [6:0]  r_prevSeg;
    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [3:0]  r_shBcd [4];
    logic [3:0]  r_shBlank;
    logic [3:0]  r_shErr;
    logic [3:0]  r_seen;
    logic [20:0] r_idleCnt;
    logic [15:0] r_digits;
    logic [3:0]  r_blank;
    logic [3:0]  r_err;
    logic        r_frameValid;
    logic        r_timeout;

    logic        w_sel;
    logic        w_same;
    logic [1:0]  w_idx;
    logic [8:0]  w_cntInc;
    logic        w_accept;
    logic        w_timeoutHit;
    logic [3:0]  w_seenNext;
    logic [3:0]  w_bcd;
    logic        w_blank;
    logic        w_err;

    // The previous sample lets the FSM tell a steady digit from a changing one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an      <= 4'hF;
            r_seg     <= 7'h7F;
            r_prevAn  <= 4'hF;
            r_prevSeg <= 7'h7F;
        end else begin
            r_an      <= an_in;
            r_seg     <= seg_in;
            r_prevAn  <= r_an;
            r_prevSeg <= r_seg;
        end
    end

    assign w_sel    = isSelected(r_an);
    assign w_same   = ({r_an, r_seg} == {r_prevAn, r_prevSeg});
    assign w_idx    = anodeIndex(r_an);
    assign w_cntInc = {1'b0, r_cnt} + 9'd1;

    always_comb begin
        w_accept = 1'b0;
        if (w_sel) begin
            case (r_state)
                IDLE:    w_accept = ONE_SHOT;
                DWELL:   w_accept = w_same ? (w_cntInc >= STABLE_W) : ONE_SHOT;
                HOLD:    w_accept = !w_same && ONE_SHOT;
                default: w_accept = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel) begin
                        r_cnt   <= 8'd1;
                        r_state <= w_accept ? HOLD : DWELL;
                    end
                end
                DWELL: begin
                    if (!w_sel) begin
                        r_state <= IDLE;
                    end else if (w_same) begin
                        r_cnt <= w_cntInc[7:0];
                        if (w_accept) r_state <= HOLD;
                    end else begin
                        r_cnt   <= 8'd1;
                        r_state <= w_accept ? HOLD : DWELL;
                    end
                end
                HOLD: begin
                    if (!w_same) begin
                        if (w_sel) begin
                            r_cnt   <= 8'd1;
                            r_state <= w_accept ? HOLD : DWELL;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    seg7_decode u_decode (
        .i_seg   (r_seg),
        .o_bcd   (w_bcd),
        .o_blank (w_blank),
        .o_err   (w_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_shBcd[i] <= 4'h0;
            r_shBlank <= 4'h0;
            r_shErr   <= 4'h0;
        end else if (w_accept) begin
            r_shBcd[w_idx]   <= w_bcd;
            r_shBlank[w_idx] <= w_blank;
            r_shErr[w_idx]   <= w_err;
        end
    end

    // An acceptance in the frame-emit cycle survives the clear and starts the next frame.
    assign w_timeoutHit = !w_accept && (r_idleCnt != TIMEOUT_W) && ((r_idleCnt + 21'd1) == TIMEOUT_W);

    always_comb begin
        w_seenNext = r_seen;
        if ((r_seen == 4'hF) || w_timeoutHit) w_seenNext = 4'h0;
        if (w_accept) w_seenNext[w_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seen       <= 4'h0;
            r_idleCnt    <= 21'd0;
            r_digits     <= 16'h0000;
            r_blank      <= 4'hF;
            r_err        <= 4'h0;
            r_frameValid <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_seen       <= w_seenNext;
            r_frameValid <= 1'b0;
            if (w_accept) begin
                r_idleCnt <= 21'd0;
            end else if (r_idleCnt != TIMEOUT_W) begin
                r_idleCnt <= r_idleCnt + 21'd1;
            end
            if (r_seen == 4'hF) begin
                r_digits     <= {r_shBcd[3], r_shBcd[2], r_shBcd[1], r_shBcd[0]};
                r_blank      <= r_shBlank;
                r_err        <= r_shErr;
                r_frameValid <= 1'b1;
                r_timeout    <= 1'b0;
            end
            if (w_timeoutHit) r_timeout <= 1'b1;
        end
    end

    assign digits_out  = r_digits;
    assign blank_out   = r_blank;
    assign err_out     = r_err;
    assign frame_valid = r_frameValid;
    assign timeout_err = r_timeout;

endmodule
